multiword_add_seq: RTL and testbench
====================================

# multiword_add_seq

Sequential multi-byte adder/subtractor that reuses one 8-bit hybrid adder slice over `NBYTES` clock cycles. It processes operands LSB byte first and chains the carry between bytes in a flop. It accepts one operation at a time over a valid/ready handshake and holds the result until the consumer takes it. It is the controller that shares the team's 8-bit adder datapath across wide arithmetic requests.

## Interface
- `NBYTES`, default 4: operand width in bytes; legal values are 1 or more; `W = 8*NBYTES`.
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  block can accept; equal to (state == IDLE).
- `a`  in  W  operand A.
- `b`  in  W  operand B.
- `cin`  in  1  carry-in for add; ignored when `sub`=1.
- `sub`  in  1  0 = A+B+cin, 1 = A−B (A + ~B + 1).
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes result.
- `sum`  out  W  result, modulo 2^W.
- `cout`  out  1  carry out of bit W−1 (for sub, 1 = no borrow).
- `ovf`  out  1  two's-complement signed overflow.

## Operation
- States are IDLE, RUN and DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: latch `a` into the A shift register and (`sub` ? ~`b` : `b`) into the B shift register.
  - Latch the carry flop with (`sub` ? 1 : `cin`).
  - Latch the MSBs of A and effective B for overflow.
  - Set byte index = 0 and go to RUN.
- **RUN**
  - Each cycle the slice computes A[7:0] + B[7:0] + carry flop.
  - On the edge, shift the 8-bit result into the top of the sum register (the register shifts right by 8).
  - Shift A and B right by 8 and load the carry flop with the slice's C8.
  - Index increments; after the index `NBYTES`−1 edge, go to DONE.
- **DONE**
  - `out_valid`=1.
  - `sum`, `cout` (the final carry flop) and `ovf` are held stable.
  - On `out_valid`&&`out_ready`, go to IDLE.
- `ovf` = (A_msb == Beff_msb) && (sum[W−1] != A_msb), evaluated when DONE is entered.
- Inputs are ignored outside the IDLE accept edge. Changes to `a`/`b`/`sub`/`cin` mid-operation have no effect.
- `sum`/`cout`/`ovf` are only meaningful while `out_valid`=1. They keep their last values in IDLE.

## Timing
- Reset values (asynchronous, while `rst_n`=0):
  - state = IDLE, so `in_ready`=1 and `out_valid`=0.
  - `sum`=0, `cout`=0, `ovf`=0.
  - Carry flop, shift registers and index are all 0.
- Latency: `out_valid` rises exactly `NBYTES` rising edges after the accept edge. For `NBYTES`=1, the RUN state lasts one cycle.
- Minimum op-to-op period: `NBYTES`+2 cycles (accept, `NBYTES` RUN edges, handshake edge). There is no accept in the same cycle as the result handshake, because `in_ready`=0 in DONE.
- Backpressure: DONE persists indefinitely while `out_ready`=0, with outputs stable.
- `out_ready` is a don't-care outside DONE.
- Reset mid-RUN or mid-DONE: the operation is abandoned immediately, with no partial result emitted. The first accept after `rst_n` rises behaves normally.
- The index counter is ceil(log2(`NBYTES`+1)) bits wide and never wraps within an operation.

## Structure
- Shared package contents:
  - state enum (IDLE, RUN, DONE);
  - `BYTE_W` = 8;
  - a function for the index width from `NBYTES`.
- One sub-module: a single instance of `hybridadder8_struct` as the per-byte datapath slice. Its inputs are the low bytes of the A/B shift registers and the carry flop. Its outputs are `Si` (sum byte) and `C8` (next carry).
- The rest is the FSM, shift registers and counter in this module.

## Test plan
All cases use `NBYTES`=4 unless stated otherwise.
- Add, a=0x00000001, b=0xFFFFFFFF, cin=0 → `sum`=0x00000000, `cout`=1, `ovf`=0; `out_valid` rises on the 4th edge after accept.
- Add, a=0x7FFFFFFF, b=0x00000001 → `sum`=0x80000000, `cout`=0, `ovf`=1. Add, a=0x000000FF, b=0x000000FF, cin=1 → `sum`=0x000001FF (carry crosses a byte boundary).
- Sub, a=5, b=7 → `sum`=0xFFFFFFFE, `cout`=0, `ovf`=0. Sub, a=0x80000000, b=1 → `sum`=0x7FFFFFFF, `cout`=1, `ovf`=1.
- Hold `out_ready`=0 for 10 cycles in DONE → `out_valid`, `sum`, `cout` and `ovf` stay stable and `in_ready`=0. `in_valid` pulses with new operands are ignored; the next accept happens only after the handshake.
- Assert `rst_n`=0 after 2 RUN edges → `in_ready`=1 and `out_valid`=0 at once, with `sum`=0. A following add, 3+4, returns 7 with normal latency.
- `NBYTES`=1, a=0xFF, b=0x01 → `sum`=0x00, `cout`=1, with `out_valid` one edge after accept. Also run a 1000-op random sweep, with random `out_ready` stalls, against a reference model.

Source files
------------

// File: rtl/multiword_add_seq_pkg.sv
// Shared types and helpers for the sequential multi-byte adder.
package multiword_add_seq_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    function automatic int unsigned idx_width(input int unsigned nbytes);
        return $clog2(nbytes + 1);
    endfunction

endpackage

// File: rtl/multiword_add_seq_hybridadder8.sv
// 8-bit hybrid adder slice: 4-bit carry-lookahead groups with ripple between the two nibbles.
module hybridadder8_struct
    import multiword_add_seq_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              c0,
    output logic [BYTE_W-1:0] si,
    output logic              c8
);

    function automatic logic [3:0] cla4(input logic [3:0] g, input logic [3:0] p, input logic ci);
        logic [3:0] c;
        c[0] = g[0] | (p[0] & ci);
        c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) |
               (p[3] & p[2] & p[1] & p[0] & ci);
        return c;
    endfunction

    logic [BYTE_W-1:0] g;
    logic [BYTE_W-1:0] p;
    logic [3:0]        c_lo;
    logic [3:0]        c_hi;

    assign g    = a & b;
    assign p    = a ^ b;
    assign c_lo = cla4(g[3:0], p[3:0], c0);
    assign c_hi = cla4(g[7:4], p[7:4], c_lo[3]);
    assign si   = p ^ {c_hi[2:0], c_lo[3], c_lo[2:0], c0};
    assign c8   = c_hi[3];

endmodule

// File: rtl/multiword_add_seq.sv
// Sequential W-bit add/subtract: one 8-bit slice reused over NBYTES cycles, LSB byte first.
module multiword_add_seq
    import multiword_add_seq_pkg::*;
#(
    parameter int unsigned NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BYTE_W*NBYTES-1:0] a,
    input  logic [BYTE_W*NBYTES-1:0] b,
    input  logic                     cin,
    input  logic                     sub,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BYTE_W*NBYTES-1:0] sum,
    output logic                     cout,
    output logic                     ovf
);

    localparam int unsigned W  = BYTE_W * NBYTES;
    localparam int unsigned IW = idx_width(NBYTES);
    localparam logic [IW-1:0] LastIdx = IW'(NBYTES - 1);

    state_e        state_q, state_d;
    logic [W-1:0]  a_sh_q, a_sh_d;
    logic [W-1:0]  b_sh_q, b_sh_d;
    logic [W-1:0]  sum_q, sum_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic          a_msb_q, a_msb_d;
    logic          b_msb_q, b_msb_d;
    logic          ovf_q, ovf_d;

    logic [W-1:0]      b_eff;
    logic [BYTE_W-1:0] slice_sum;
    logic              slice_c8;

    assign b_eff = sub ? ~b : b;

    hybridadder8_struct u_slice (
        .a  (a_sh_q[BYTE_W-1:0]),
        .b  (b_sh_q[BYTE_W-1:0]),
        .c0 (carry_q),
        .si (slice_sum),
        .c8 (slice_c8)
    );

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b_eff;
                    carry_d = sub | cin;
                    a_msb_d = a[W-1];
                    b_msb_d = b_eff[W-1];
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_sh_d  = a_sh_q >> BYTE_W;
                b_sh_d  = b_sh_q >> BYTE_W;
                // Result bytes enter at the top so the LSB byte ends up at bit 0.
                sum_d   = (sum_q >> BYTE_W) | (W'(slice_sum) << (W - BYTE_W));
                carry_d = slice_c8;
                idx_d   = idx_q + IW'(1);
                if (idx_q == LastIdx) begin
                    ovf_d   = (a_msb_q == b_msb_q) && (slice_sum[BYTE_W-1] != a_msb_q);
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign sum       = sum_q;
    assign cout      = carry_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed-vector and random-sweep bench for multiword_add_seq (NBYTES=4 and NBYTES=1).
module tb_multiword_add_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, cin = 1'b0, sub = 1'b0, out_ready = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        in_ready, out_valid, cout, ovf;
    logic [31:0] sum;

    logic        in_valid1 = 1'b0, cin1 = 1'b0, sub1 = 1'b0, out_ready1 = 1'b0;
    logic [7:0]  a1 = '0, b1 = '0;
    logic        in_ready1, out_valid1, cout1, ovf1;
    logic [7:0]  sum1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multiword_add_seq #(.NBYTES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    multiword_add_seq #(.NBYTES(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
        .sub       (sub1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .cout      (cout1),
        .ovf       (ovf1)
    );

    typedef struct {
        logic [31:0] va;
        logic [31:0] vb;
        logic        vcin;
        logic        vsub;
        logic [31:0] esum;
        logic        ecout;
        logic        eovf;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [31:0] ta, input logic [31:0] tb_, input logic tcin,
                            input logic tsub);
        @(negedge clk);
        a = ta; b = tb_; cin = tcin; sub = tsub; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
    endtask

    // Counts edges after the accept edge until out_valid; out_ready is noise during RUN.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            out_ready = 1'($urandom);
            @(posedge clk);
            #1;
            lat++;
        end
        out_ready = 1'b0;
    endtask

    task automatic finish_op();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    function automatic logic [33:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                         input logic mcin, input logic msub);
        logic [31:0] beff;
        logic [32:0] r;
        logic        o;
        beff = msub ? ~mb : mb;
        r    = {1'b0, ma} + {1'b0, beff} + {32'd0, msub ? 1'b1 : mcin};
        o    = (ma[31] == beff[31]) && (r[31] != ma[31]);
        return {o, r};
    endfunction

    initial begin
        vec_t        vecs[8];
        int          lat;
        logic [31:0] hs;
        logic        hc, ho;
        logic [31:0] ra, rb;
        logic        rc, rsub;
        logic [33:0] exp;

        vecs[0] = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[2] = '{32'h0000_00FF, 32'h0000_00FF, 1'b1, 1'b0, 32'h0000_01FF, 1'b0, 1'b0};
        vecs[3] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[5] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0};
        vecs[6] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 32'hACF1_3569, 1'b0, 1'b0};
        vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};

        #12;
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset sum/cout/ovf", {30'd0, sum, cout, ovf}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            start_op(vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].vsub);
            wait_done(lat);
            chk($sformatf("vec%0d latency", i), 64'(lat), 64'd4);
            chk($sformatf("vec%0d sum", i), 64'(sum), 64'(vecs[i].esum));
            chk($sformatf("vec%0d cout/ovf", i), {62'd0, cout, ovf},
                {62'd0, vecs[i].ecout, vecs[i].eovf});
            finish_op();
            chk($sformatf("vec%0d back to idle", i), {62'd0, in_ready, out_valid}, 64'd2);
        end

        // Backpressure: result held, new requests ignored until the handshake.
        start_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        wait_done(lat);
        hs = sum; hc = cout; ho = ovf;
        chk("bp initial result", {30'd0, hs, hc, ho}, {30'd0, 32'h8000_0000, 1'b0, 1'b1});
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = $urandom; b = $urandom;
            @(posedge clk);
            #1;
            chk($sformatf("bp hold %0d", i), {28'd0, in_ready, out_valid, sum, cout, ovf},
                {28'd0, 1'b0, 1'b1, hs, hc, ho});
        end
        in_valid = 1'b0;
        finish_op();
        start_op(32'h0000_0100, 32'h0000_0023, 1'b0, 1'b0);
        wait_done(lat);
        chk("bp next op", {23'd0, lat[7:0], sum, cout}, {23'd0, 8'd4, 32'h0000_0123, 1'b0});
        finish_op();

        // Reset after two RUN edges abandons the operation.
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrun reset", {30'd0, in_ready, out_valid, sum}, {30'd0, 1'b1, 1'b0, 32'd0});
        @(negedge clk);
        rst_n = 1'b1;
        start_op(32'd3, 32'd4, 1'b0, 1'b0);
        wait_done(lat);
        chk("post-reset 3+4", {23'd0, lat[7:0], sum, cout}, {23'd0, 8'd4, 32'd7, 1'b0});
        finish_op();

        // NBYTES=1: result one edge after accept.
        @(negedge clk);
        a1 = 8'hFF; b1 = 8'h01; cin1 = 1'b0; sub1 = 1'b0; in_valid1 = 1'b1;
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        chk("n1 out_valid before edge", 64'(out_valid1), 64'd0);
        @(posedge clk);
        #1;
        chk("n1 result", {54'd0, out_valid1, sum1, cout1}, {54'd0, 1'b1, 8'h00, 1'b1});
        @(negedge clk);
        out_ready1 = 1'b1;
        @(posedge clk);
        #1;
        out_ready1 = 1'b0;
        chk("n1 idle", {62'd0, in_ready1, out_valid1}, 64'd2);

        // Random sweep with result stalls.
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom); rsub = 1'($urandom);
            if (i % 7 == 0) rb = ra;
            exp = model(ra, rb, rc, rsub);
            start_op(ra, rb, rc, rsub);
            wait_done(lat);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            chk($sformatf("rand%0d a=%h b=%h cin=%0d sub=%0d", i, ra, rb, rc, rsub),
                {22'd0, lat[7:0], out_valid, ovf, cout, sum},
                {22'd0, 8'd4, 1'b1, exp[33], exp[32], exp[31:0]});
            finish_op();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
